// File: rtl/uncache_data_bridge_pkg.sv
// rtl/uncache_data_bridge_pkg.sv - shared encodings for the uncached data bridge
//
// Purpose: FSM state encoding, access-size and bus response codes, and the
//          width of the packed request bundle the MEM stage hands over.
// Ports:   none (package).
package uncache_data_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_AR   = 3'd1,
    ST_RD_R    = 3'd2,
    ST_WR_AW_W = 3'd3,
    ST_WR_B    = 3'd4,
    ST_RESP    = 3'd5
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  // Packed request layout, MSB first: {wr, size[1:0], addr, wstrb[3:0], wdata}
  function automatic int mem_to_bridge_bus_width(input int addr_w, input int data_w);
    return 1 + 2 + addr_w + 4 + data_w;
  endfunction

  // The pipeline's size code 3 is an alias for a word access.
  function automatic logic [2:0] axi_size(input logic [1:0] size);
    return (size == 2'd3) ? {1'b0, SIZE_WORD} : {1'b0, size};
  endfunction

endpackage

// File: rtl/uncache_data_bridge.sv
// rtl/uncache_data_bridge.sv - sram-like uncached request to single AXI-style transaction
//
// Purpose: accepts one MEM-stage request at a time (req/addr_ok/data_ok) and
//          turns it into one AXI-style read (AR/R) or write (AW/W/B) burst of
//          length one. Returns the whole read word; MEM does lane extraction.
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   req_i, wr_i, size_i, addr_i,    request from MEM
//   wstrb_i, wdata_i, cancel_i
//   addr_ok_o, data_ok_o, rdata_o,  response to MEM
//   bus_err_o
//   ar*/r*/aw*/w*/b*                AXI-style channels toward the bus arbiter
module uncache_data_bridge
  import uncache_data_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_i,
  input  logic              wr_i,
  input  logic [1:0]        size_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [3:0]        wstrb_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              cancel_i,
  output logic              addr_ok_o,
  output logic              data_ok_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              bus_err_o,
  output logic              arvalid_o,
  output logic [ADDR_W-1:0] araddr_o,
  output logic [2:0]        arsize_o,
  input  logic              arready_i,
  input  logic              rvalid_i,
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [1:0]        rresp_i,
  output logic              rready_o,
  output logic              awvalid_o,
  output logic [ADDR_W-1:0] awaddr_o,
  output logic [2:0]        awsize_o,
  input  logic              awready_i,
  output logic              wvalid_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic [3:0]        wstrb_o,
  input  logic              wready_i,
  input  logic              bvalid_i,
  input  logic [1:0]        bresp_i,
  output logic              bready_o
);

  localparam int REQ_W     = mem_to_bridge_bus_width(ADDR_W, DATA_W);
  localparam int WSTRB_LSB = DATA_W;
  localparam int ADDR_LSB  = DATA_W + 4;
  localparam int SIZE_LSB  = DATA_W + 4 + ADDR_W;
  localparam int WR_BIT    = REQ_W - 1;

  state_t            state_q, state_d;
  logic [REQ_W-1:0]  req_q;
  logic              aw_done_q, w_done_q;
  logic              err_q;
  logic              cancel_q;
  logic [DATA_W-1:0] rdata_q;
  logic              accept;
  logic              aw_all, w_all;

  logic              req_wr;
  logic [1:0]        req_size;
  logic [ADDR_W-1:0] req_addr;
  logic [3:0]        req_wstrb;
  logic [DATA_W-1:0] req_wdata;

  assign req_wr    = req_q[WR_BIT];
  assign req_size  = req_q[SIZE_LSB +: 2];
  assign req_addr  = req_q[ADDR_LSB +: ADDR_W];
  assign req_wstrb = req_q[WSTRB_LSB +: 4];
  assign req_wdata = req_q[DATA_W-1:0];

  assign araddr_o = req_addr;
  assign arsize_o = axi_size(req_size);
  assign awaddr_o = req_addr;
  assign awsize_o = axi_size(req_size);
  assign wdata_o  = req_wdata;
  assign wstrb_o  = req_wstrb;
  assign rdata_o  = rdata_q;

  // A channel counts as done once its handshake has happened, whether in an
  // earlier cycle (flag) or right now (ready seen while valid is still up).
  assign aw_all = aw_done_q | awready_i;
  assign w_all  = w_done_q  | wready_i;

  always_comb begin
    state_d   = state_q;
    addr_ok_o = 1'b0;
    accept    = 1'b0;
    arvalid_o = 1'b0;
    rready_o  = 1'b0;
    awvalid_o = 1'b0;
    wvalid_o  = 1'b0;
    bready_o  = 1'b0;
    data_ok_o = 1'b0;
    bus_err_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Gated by rst_n so nothing looks ready while reset is held.
        addr_ok_o = ~cancel_i & rst_n;
        accept    = req_i & addr_ok_o;
        if (accept) state_d = wr_i ? ST_WR_AW_W : ST_RD_AR;
      end
      ST_RD_AR: begin
        arvalid_o = 1'b1;
        if (arready_i) state_d = ST_RD_R;
      end
      ST_RD_R: begin
        rready_o = 1'b1;
        if (rvalid_i) state_d = ST_RESP;
      end
      ST_WR_AW_W: begin
        awvalid_o = ~aw_done_q;
        wvalid_o  = ~w_done_q;
        if (aw_all && w_all) state_d = ST_WR_B;
      end
      ST_WR_B: begin
        bready_o = 1'b1;
        if (bvalid_i) state_d = ST_RESP;
      end
      ST_RESP: begin
        data_ok_o = ~cancel_q;
        bus_err_o = err_q;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      req_q     <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      err_q     <= 1'b0;
      cancel_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q <= state_d;

      if (accept) req_q <= {wr_i, size_i, addr_i, wstrb_i, wdata_i};

      if (state_q == ST_WR_AW_W) begin
        if (aw_all && w_all) begin
          aw_done_q <= 1'b0;
          w_done_q  <= 1'b0;
        end else begin
          aw_done_q <= aw_all;
          w_done_q  <= w_all;
        end
      end

      if (state_q == ST_RD_R && rvalid_i) begin
        rdata_q <= rdata_i;
        err_q   <= (rresp_i != RESP_OKAY);
      end
      if (state_q == ST_WR_B && bvalid_i) begin
        err_q <= (bresp_i != RESP_OKAY);
      end

      // Only loads can be cancelled; the flag dies as we return to IDLE.
      if (state_q == ST_RESP)
        cancel_q <= 1'b0;
      else if (cancel_i && !req_wr && (state_q == ST_RD_AR || state_q == ST_RD_R))
        cancel_q <= 1'b1;
    end
  end

endmodule
